// File: rtl/xgmii_pkg.sv
// XGMII control characters and scheduler state encoding.
// Shared between the TX scheduler and the 64b/66b encoder.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE      = 8'h07;
  localparam logic [7:0] XGMII_START     = 8'hFB;
  localparam logic [7:0] XGMII_TERMINATE = 8'hFD;
  localparam logic [7:0] XGMII_ERROR     = 8'hFE;
  localparam logic [7:0] PREAMBLE        = 8'h55;
  localparam logic [7:0] SFD             = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_TERM,
    S_ERR,
    S_DRAIN
  } tx_state_t;

  function automatic logic [2:0] lane_count(
    input logic [3:0] keep
  );
    lane_count = 3'(keep[0]) + 3'(keep[1])
               + 3'(keep[2]) + 3'(keep[3]);
  endfunction

endpackage

// File: rtl/xgmii_term_builder.sv
// Builds a terminate word: k data lanes, /T/ in lane k,
// idles above it.
module xgmii_term_builder
  import xgmii_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  lanes,
  output logic [31:0] term_data,
  output logic [3:0]  term_ctrl
);

  always_comb begin
    term_data = '0;
    term_ctrl = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < lanes) begin
        term_data[8*i +: 8] = data[8*i +: 8];
        term_ctrl[i]        = 1'b0;
      end else if (3'(i) == lanes) begin
        term_data[8*i +: 8] = XGMII_TERMINATE;
        term_ctrl[i]        = 1'b1;
      end else begin
        term_data[8*i +: 8] = XGMII_IDLE;
        term_ctrl[i]        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_scheduler.sv
// MAC frame to XGMII word sequencer with IPG and lane-0 start.
// Define XGMII_S4_START_EN to allow starts on the odd half-block.
module xgmii_tx_scheduler
  import xgmii_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = 4,
  parameter int MIN_IPG_BYTES    = 12
) (
  input  logic                        tx_clk,
  input  logic                        tx_rst,
  input  logic [XGMII_DATA_WIDTH-1:0] s_tdata,
  input  logic [XGMII_DATA_BYTES-1:0] s_tkeep,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  output logic [XGMII_DATA_WIDTH-1:0] xgmii_data_out,
  output logic [XGMII_DATA_BYTES-1:0] xgmii_ctrl_out,
  input  logic                        xgmii_ready_in,
  output logic                        frame_done,
  output logic                        underrun
);

  tx_state_t   state, state_n;
  logic        phase;
  logic [7:0]  ipg_cnt, ipg_n;
  logic        term_q, term_n;
  logic [31:0] data_n;
  logic [3:0]  ctrl_n;
  logic        done_n, unr_n;
  logic [2:0]  lanes;
  logic [31:0] t_data;
  logic [3:0]  t_ctrl;
  logic        aligned;
  logic        start;
  logic        from_input;

  assign lanes = lane_count(s_tkeep);

`ifdef XGMII_S4_START_EN
  assign aligned = 1'b1;
`else
  // phase 1 now means the next word opens a block
  assign aligned = phase;
`endif

  assign from_input = (state == S_SFD)
                   || (state == S_DATA);
  assign s_tready = (state == S_DRAIN)
                 || (xgmii_ready_in && from_input);
  assign start = s_tvalid && aligned
              && (ipg_cnt >= 8'(MIN_IPG_BYTES));

  xgmii_term_builder u_term (
    .data      (s_tdata),
    .lanes     (lanes),
    .term_data (t_data),
    .term_ctrl (t_ctrl)
  );

  always_comb begin
    state_n = state;
    ipg_n   = ipg_cnt;
    term_n  = term_q;
    data_n  = xgmii_data_out;
    ctrl_n  = xgmii_ctrl_out;
    done_n  = 1'b0;
    unr_n   = 1'b0;
    if (xgmii_ready_in) begin
      unique case (state)
        S_IDLE: begin
          done_n = term_q;
          term_n = 1'b0;
          if (start) begin
            state_n = S_PRE;
            data_n  = {{3{PREAMBLE}}, XGMII_START};
            ctrl_n  = 4'b0001;
          end else begin
            data_n = {4{XGMII_IDLE}};
            ctrl_n = 4'hF;
            ipg_n  = (ipg_cnt > 8'd251) ? 8'hFF
                   : ipg_cnt + 8'd4;
          end
        end
        S_PRE: begin
          state_n = S_SFD;
          data_n  = {SFD, {3{PREAMBLE}}};
          ctrl_n  = 4'b0000;
        end
        S_SFD, S_DATA: begin
          if (!s_tvalid) begin
            state_n = S_ERR;
            data_n  = {4{XGMII_ERROR}};
            ctrl_n  = 4'hF;
            unr_n   = 1'b1;
          end else if (s_tlast && lanes < 3'd4) begin
            state_n = S_IDLE;
            data_n  = t_data;
            ctrl_n  = t_ctrl;
            ipg_n   = {5'd0, 3'd4 - lanes};
            term_n  = 1'b1;
          end else begin
            state_n = s_tlast ? S_TERM : S_DATA;
            data_n  = s_tdata;
            ctrl_n  = 4'b0000;
          end
        end
        S_TERM: begin
          state_n = S_IDLE;
          data_n  = {{3{XGMII_IDLE}}, XGMII_TERMINATE};
          ctrl_n  = 4'hF;
          ipg_n   = 8'd4;
          term_n  = 1'b1;
        end
        S_ERR: begin
          state_n = S_DRAIN;
          data_n  = {4{XGMII_IDLE}};
          ctrl_n  = 4'hF;
        end
        S_DRAIN: begin
          data_n = {4{XGMII_IDLE}};
          ctrl_n = 4'hF;
        end
        default: state_n = S_IDLE;
      endcase
    end
    // drain accepts beats even while the encoder stalls
    if (state == S_DRAIN && s_tvalid && s_tlast) begin
      state_n = S_IDLE;
      ipg_n   = 8'd0;
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst) begin
    if (!tx_rst) begin
      state          <= S_IDLE;
      phase          <= 1'b0;
      ipg_cnt        <= 8'hFF;
      term_q         <= 1'b0;
      xgmii_data_out <= {4{XGMII_IDLE}};
      xgmii_ctrl_out <= 4'hF;
      frame_done     <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state          <= state_n;
      ipg_cnt        <= ipg_n;
      term_q         <= term_n;
      xgmii_data_out <= data_n;
      xgmii_ctrl_out <= ctrl_n;
      frame_done     <= done_n;
      underrun       <= unr_n;
      if (xgmii_ready_in) phase <= ~phase;
    end
  end

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed bench for xgmii_tx_scheduler: framing, IPG,
// back-pressure, underrun and reset.
module tb_xgmii_tx_scheduler;

  logic        tx_clk = 1'b0;
  logic        tx_rst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] xgmii_data_out;
  logic [3:0]  xgmii_ctrl_out;
  logic        xgmii_ready_in;
  logic        frame_done;
  logic        underrun;

  always #5 tx_clk = ~tx_clk;

  xgmii_tx_scheduler dut (
    .tx_clk         (tx_clk),
    .tx_rst         (tx_rst),
    .s_tdata        (s_tdata),
    .s_tkeep        (s_tkeep),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tready       (s_tready),
    .xgmii_data_out (xgmii_data_out),
    .xgmii_ctrl_out (xgmii_ctrl_out),
    .xgmii_ready_in (xgmii_ready_in),
    .frame_done     (frame_done),
    .underrun       (underrun)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        gap;
  } beat_t;

  localparam logic [35:0] W_IDLE = 36'h07070707F;
  localparam logic [35:0] W_PRE  = 36'h555555FB1;
  localparam logic [35:0] W_SFD  = 36'hD55555550;
  localparam logic [35:0] W_TERM = 36'h070707FDF;
  localparam logic [35:0] W_ERR  = 36'hFEFEFEFEF;

`ifdef XGMII_S4_START_EN
  localparam int GAP_A = 13;
  localparam int GAP_B = 7;
`else
  localparam int GAP_A = 14;
  localparam int GAP_B = 8;
`endif

  beat_t       beats[$];
  logic [35:0] log_q[$];
  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_unr  = 0;

  task automatic check(input string tag,
                       input logic [35:0] got,
                       input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] d,
                     input logic [3:0] k,
                     input logic l,
                     input logic g);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    b.gap  = g;
    beats.push_back(b);
  endtask

  task automatic drive();
    if (beats.size() != 0 && !beats[0].gap) begin
      s_tvalid = 1'b1;
      s_tdata  = beats[0].data;
      s_tkeep  = beats[0].keep;
      s_tlast  = beats[0].last;
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge tx_clk);
    if (xgmii_ready_in)
      log_q.push_back({xgmii_data_out, xgmii_ctrl_out});
    if (frame_done) n_done++;
    if (underrun) n_unr++;
    if (beats.size() != 0)
      if (beats[0].gap || (s_tvalid && s_tready))
        void'(beats.pop_front());
    @(posedge tx_clk);
    #1;
    drive();
  endtask

  function automatic logic [35:0] word_at(input int i);
    if (i >= 0 && i < log_q.size()) return log_q[i];
    return 36'h0;
  endfunction

  function automatic int find_pre(input int from);
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i] == W_PRE) return i;
    return -1;
  endfunction

  initial begin
    int base, p, p2, p3, pf, n, d0, u0, nonidle;
    logic [31:0] dv;

    tx_rst = 1'b0;
    xgmii_ready_in = 1'b1;
    drive();
    repeat (2) @(posedge tx_clk);
    #1;
    check("rst_word",
          {xgmii_data_out, xgmii_ctrl_out}, W_IDLE);
    check("rst_tready", s_tready, 0);
    check("rst_done", frame_done, 0);
    check("rst_unr", underrun, 0);
    tx_rst = 1'b1;

    repeat (8) tick();
    nonidle = 0;
    foreach (log_q[i]) if (log_q[i] != W_IDLE) nonidle++;
    check("idle_run", nonidle, 0);
    check("idle_done", n_done, 0);
    check("idle_unr", n_unr, 0);

    // frames A (8 full), B (k=2), C (1 beat)
    base = log_q.size();
    d0 = n_done;
    for (int i = 0; i < 8; i++)
      add(32'hA0000000 + i, 4'hF, i == 7, 1'b0);
    add(32'h11223344, 4'hF, 1'b0, 1'b0);
    add(32'h9999BBAA, 4'h3, 1'b1, 1'b0);
    add(32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    repeat (70) tick();
    p = find_pre(base);
    check("a_found", p >= 0, 1);
    check("a_phase", p % 2, 0);
    check("a_sfd", word_at(p + 1), W_SFD);
    for (int i = 0; i < 8; i++) begin
      dv = 32'hA0000000 + i;
      check("a_data", word_at(p + 2 + i), {dv, 4'h0});
    end
    check("a_term", word_at(p + 10), W_TERM);
    for (int i = 11; i < GAP_A; i++)
      check("a_ipg", word_at(p + i), W_IDLE);
    p2 = p + GAP_A;
    check("b_pre", word_at(p2), W_PRE);
    check("b_sfd", word_at(p2 + 1), W_SFD);
    check("b_data", word_at(p2 + 2), 36'h112233440);
    check("b_term", word_at(p2 + 3), 36'h07FDBBAAC);
    for (int i = 4; i < GAP_B; i++)
      check("b_ipg", word_at(p2 + i), W_IDLE);
    p3 = p2 + GAP_B;
    check("c_pre", word_at(p3), W_PRE);
    check("c_data", word_at(p3 + 2), 36'hCAFEF00D0);
    check("c_term", word_at(p3 + 3), W_TERM);
    check("abc_done", n_done - d0, 3);
    check("abc_empty", beats.size(), 0);

    // frame D with encoder stall on beat 2
    base = log_q.size();
    d0 = n_done;
    for (int i = 0; i < 6; i++)
      add(32'hD0000000 + i, 4'hF, i == 5, 1'b0);
    n = 0;
    while (xgmii_data_out !== 32'hD0000002 && n < 50) begin
      tick();
      n++;
    end
    check("d_reach", n < 50, 1);
    xgmii_ready_in = 1'b0;
    repeat (3) begin
      tick();
      check("hold_word",
            {xgmii_data_out, xgmii_ctrl_out}, 36'hD00000020);
      check("hold_tready", s_tready, 0);
    end
    check("hold_beats", beats.size(), 3);
    xgmii_ready_in = 1'b1;
    repeat (30) tick();
    p = find_pre(base);
    check("d_found", p >= 0, 1);
    check("d_phase", p % 2, 0);
    for (int i = 0; i < 6; i++) begin
      dv = 32'hD0000000 + i;
      check("d_data", word_at(p + 2 + i), {dv, 4'h0});
    end
    check("d_term", word_at(p + 8), W_TERM);
    check("d_done", n_done - d0, 1);

    // frame E underruns after beat 3; F (k=3) follows
    base = log_q.size();
    d0 = n_done;
    u0 = n_unr;
    for (int i = 0; i < 3; i++)
      add(32'hE0000000 + i, 4'hF, 1'b0, 1'b0);
    add(32'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 3; i < 6; i++)
      add(32'hE0000000 + i, 4'hF, i == 5, 1'b0);
    add(32'h44332211, 4'h7, 1'b1, 1'b0);
    repeat (50) tick();
    p = find_pre(base);
    check("e_found", p >= 0, 1);
    for (int i = 0; i < 3; i++) begin
      dv = 32'hE0000000 + i;
      check("e_data", word_at(p + 2 + i), {dv, 4'h0});
    end
    check("e_err", word_at(p + 5), W_ERR);
    for (int i = 6; i < 9; i++)
      check("e_drain", word_at(p + i), W_IDLE);
    check("e_unr", n_unr - u0, 1);
    pf = find_pre(p + 1);
    check("f_found", pf > p + 8, 1);
    check("f_term", word_at(pf + 2), 36'hFD3322118);
    check("ef_done", n_done - d0, 1);
    check("ef_empty", beats.size(), 0);

    // reset in the middle of a frame
    for (int i = 0; i < 4; i++)
      add(32'h77000000 + i, 4'hF, i == 3, 1'b0);
    n = 0;
    while (xgmii_ctrl_out !== 4'h0 && n < 40) begin
      tick();
      n++;
    end
    check("r_reach", n < 40, 1);
    tx_rst = 1'b0;
    #1;
    check("r_word",
          {xgmii_data_out, xgmii_ctrl_out}, W_IDLE);
    check("r_tready", s_tready, 0);
    beats.delete();
    drive();
    @(posedge tx_clk);
    #1;
    tx_rst = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
